lfsr_word_packer: RTL and testbench

//   Downstream stage of the serial LFSR: drives its shift enable, captures its

---
 rtl/lfsr_word_packer_if.sv | 21 ++
 rtl/lfsr_word_packer.sv | 105 ++++++++++
 tb/tb_lfsr_word_packer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_word_packer_if.sv
// Word-stream handshake between the packer FIFO and its consumer.
// The master drives data/valid and the slave answers with ready.
interface lfsr_word_packer_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/lfsr_word_packer.sv
// Packs the serial LFSR output into words, queues them in a FWFT FIFO, and stops
// the LFSR when the FIFO has no room for the word being assembled.
module lfsr_word_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 run,
    input  logic                                 clear,
    input  logic                                 bit_in,
    output logic                                 shift_en,
    lfsr_word_packer_if.master                   word_if,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fill_level,
    output logic [$clog2(WORD_W)-1:0]            bit_cnt,
    output logic [15:0]                          word_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_next;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic full;
    logic not_empty;
    logic word_done;
    logic push;
    logic pop;

    assign full      = (fill_level == FULL_LVL);
    assign not_empty = (fill_level != '0);
    assign word_done = (bit_cnt == LAST_BIT);

    // The stall only bites on the last bit: the partial word keeps filling while full.
    assign shift_en = rst_n & run & ~clear & ~(word_done & full);
    assign push     = shift_en & word_done;
    assign pop      = not_empty & word_if.word_ready & ~clear;

    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST) begin
            shreg_next = {shreg[WORD_W-2:0], bit_in};
        end else begin
            shreg_next = {bit_in, shreg[WORD_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            word_count <= '0;
        end else if (clear) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            word_count <= '0;
        end else begin
            if (shift_en) begin
                shreg   <= shreg_next;
                bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
            end
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                word_count <= word_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + CNT_W'(1);
                2'b01:   fill_level <= fill_level - CNT_W'(1);
                default: fill_level <= fill_level;
            endcase
        end
    end

    // Storage is never reset; emptiness is tracked solely by fill_level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shreg_next;
        end
    end

    assign word_if.word_valid = not_empty;
    assign word_if.word_data  = not_empty ? mem[rd_ptr] : '0;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_level_bound : assert property (@(posedge clk) disable iff (!rst_n) fill_level <= FULL_LVL);

endmodule

// File: tb/tb_lfsr_word_packer.sv
// Self-checking bench for lfsr_word_packer: cycle table for basic packing, hand-written
// sequences for stall/clear/reset, and an LFSR-driven stream against a golden word list.
module tb_lfsr_word_packer;

    localparam logic [31:0] SEED = 32'h0000_3039;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       clear;
    logic       bit_in;
    logic       ready;

    logic       shift_en,   shift_en_lsb;
    logic [2:0] fill_level, fill_lsb;
    logic [2:0] bit_cnt,    bit_cnt_lsb;
    logic [15:0] word_count, count_lsb;

    lfsr_word_packer_if #(.WORD_W(8)) msb_bus ();
    lfsr_word_packer_if #(.WORD_W(8)) lsb_bus ();

    assign msb_bus.word_ready = ready;
    assign lsb_bus.word_ready = ready;

    lfsr_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .clear      (clear),
        .bit_in     (bit_in),
        .shift_en   (shift_en),
        .word_if    (msb_bus),
        .fill_level (fill_level),
        .bit_cnt    (bit_cnt),
        .word_count (word_count)
    );

    lfsr_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .clear      (clear),
        .bit_in     (bit_in),
        .shift_en   (shift_en_lsb),
        .word_if    (lsb_bus),
        .fill_level (fill_lsb),
        .bit_cnt    (bit_cnt_lsb),
        .word_count (count_lsb)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic       bit_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;
    logic [7:0] part_word = '0;
    int         part_n    = 0;
    int         consumed  = 0;
    logic       lfsr_mode   = 1'b0;
    logic       golden_mode = 1'b0;
    logic [31:0] lfsr = SEED;

    typedef struct {
        logic        run;
        logic        ready;
        logic [2:0]  exp_bit_cnt;
        logic [2:0]  exp_fill;
        logic        exp_valid;
        logic [15:0] exp_count;
        logic [7:0]  exp_lsb;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        run   = v.run;
        ready = v.ready;
        @(posedge clk);
        #1;
    endtask

    task automatic clearPulse();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (fill_level == 3'd0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_fill", 32'(fill_level), 32'd0);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Bit source plus scoreboard, evaluated mid-cycle so values are stable for the next edge.
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            exp_q.delete();
            part_n    = 0;
            part_word = '0;
        end else if (msb_bus.word_valid && ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_word: got %0h, expected no word", msb_bus.word_data);
            end else begin
                exp_word = exp_q.pop_front();
                checkOutput("pop_word", 32'(msb_bus.word_data), 32'(exp_word));
            end
        end

        if (lfsr_mode)             bit_in = lfsr[31];
        else if (bit_q.size() > 0) bit_in = bit_q[0];
        else                       bit_in = 1'($urandom_range(0, 1));

        if (shift_en) begin
            consumed++;
            if (lfsr_mode) lfsr = lfsr_step(lfsr);
            else if (bit_q.size() > 0) void'(bit_q.pop_front());
            if (!golden_mode) begin
                part_word = {part_word[6:0], bit_in};
                part_n++;
                if (part_n == 8) begin
                    exp_q.push_back(part_word);
                    part_n = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] s;
        logic [7:0]  w;

        vecs[0]  = '{1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 16'd0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 16'd0, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 3'd3, 3'd0, 1'b0, 16'd0, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 3'd4, 3'd0, 1'b0, 16'd0, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 16'd0, 8'h00};
        vecs[5]  = '{1'b1, 1'b1, 3'd6, 3'd0, 1'b0, 16'd0, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 3'd7, 3'd0, 1'b0, 16'd0, 8'h00};
        vecs[7]  = '{1'b1, 1'b1, 3'd0, 3'd1, 1'b1, 16'd1, 8'h4D};
        vecs[8]  = '{1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 16'd1, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 16'd1, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 16'd1, 8'h00};
        vecs[11] = '{1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 16'd1, 8'h00};

        rst_n = 1'b0;
        run   = 1'b1;
        clear = 1'b0;
        ready = 1'b0;
        bit_in = 1'b0;

        // Reset held with run asserted.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_shift_en", 32'(shift_en), 32'd0);
        checkOutput("rst_shift_en_lsb", 32'(shift_en_lsb), 32'd0);
        checkOutput("rst_valid", 32'(msb_bus.word_valid), 32'd0);
        checkOutput("rst_fill", 32'(fill_level), 32'd0);
        checkOutput("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("rst_data", 32'(msb_bus.word_data), 32'd0);
        run   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known bit pattern, both bit orders.
        bit_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_bit_cnt", i), 32'(bit_cnt), 32'(vecs[i].exp_bit_cnt));
            checkOutput($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(vecs[i].exp_fill));
            checkOutput($sformatf("vec%0d_valid", i), 32'(msb_bus.word_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_count", i), 32'(word_count), 32'(vecs[i].exp_count));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_msb_data", i), 32'(msb_bus.word_data), 32'h0000_00B2);
                checkOutput($sformatf("vec%0d_lsb_data", i), 32'(lsb_bus.word_data), 32'(vecs[i].exp_lsb));
                checkOutput($sformatf("vec%0d_lsb_count", i), 32'(count_lsb), 32'(vecs[i].exp_count));
                checkOutput($sformatf("vec%0d_lsb_fill", i), 32'(fill_lsb), 32'(vecs[i].exp_fill));
                checkOutput($sformatf("vec%0d_lsb_bit_cnt", i), 32'(bit_cnt_lsb), 32'(vecs[i].exp_bit_cnt));
            end
        end
        run = 1'b0;

        // Backpressure: fill the FIFO, stall on the last bit, then release.
        clearPulse();
        ready = 1'b0;
        run   = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("bp_fill", 32'(fill_level), 32'd4);
        checkOutput("bp_bit_cnt", 32'(bit_cnt), 32'd7);
        checkOutput("bp_shift_en", 32'(shift_en), 32'd0);
        ready = 1'b1;
        #1;
        checkOutput("bp_shift_en_ready", 32'(shift_en), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bp_fill_after_pop", 32'(fill_level), 32'd3);
        checkOutput("bp_shift_en_resume", 32'(shift_en), 32'd1);
        run = 1'b0;
        waitDrain(20);

        // Clear with a partial word and two queued words.
        clearPulse();
        ready = 1'b0;
        run   = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        checkOutput("clr_pre_bit_cnt", 32'(bit_cnt), 32'd5);
        checkOutput("clr_pre_fill", 32'(fill_level), 32'd2);
        clear = 1'b1;
        #1;
        checkOutput("clr_shift_en", 32'(shift_en), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        run   = 1'b0;
        checkOutput("clr_bit_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("clr_fill", 32'(fill_level), 32'd0);
        checkOutput("clr_valid", 32'(msb_bus.word_valid), 32'd0);
        checkOutput("clr_count", 32'(word_count), 32'd0);

        // Asynchronous reset in the middle of a cycle.
        run = 1'b1;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("amid_bit_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("amid_fill", 32'(fill_level), 32'd0);
        checkOutput("amid_valid", 32'(msb_bus.word_valid), 32'd0);
        checkOutput("amid_count", 32'(word_count), 32'd0);
        checkOutput("amid_shift_en", 32'(shift_en), 32'd0);
        @(posedge clk);
        #1;
        run   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LFSR stream against golden words grouped MSB-first.
        exp_q.delete();
        s = SEED;
        for (int wi = 0; wi < 25; wi++) begin
            w = '0;
            for (int b = 0; b < 8; b++) begin
                w = {w[6:0], s[31]};
                s = lfsr_step(s);
            end
            exp_q.push_back(w);
        end
        golden_mode = 1'b1;
        lfsr_mode   = 1'b1;
        lfsr        = SEED;
        consumed    = 0;
        run         = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            ready = 1'($urandom_range(0, 1));
            if (consumed >= 200) run = 1'b0;
            if (consumed >= 200 && fill_level == 3'd0) break;
        end
        run = 1'b0;
        checkOutput("lfsr_bits", 32'(consumed), 32'd200);
        checkOutput("lfsr_words_left", 32'(exp_q.size()), 32'd0);
        checkOutput("lfsr_count", 32'(word_count), 32'd25);
        checkOutput("lfsr_bit_cnt", 32'(bit_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
